// File: rtl/ble_framer_pkg.sv
// -----------------------------------------------------------------------------
// ble_framer_pkg
//   Shared types and constants for the BLE bit framer.
//   - framer_state_t : framer FSM encoding (HUNT / HEADER / PAYLOAD)
//   - ADV_ACCESS_ADDR: advertising-channel access address
//   - PREAMBLE_AA/55 : the two legal preamble bytes
//   - HEADER_BYTES   : PDU header length in bytes (header0 + length)
//   - preamble_for() : preamble byte that precedes a given access address
// -----------------------------------------------------------------------------
package ble_framer_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2
   } framer_state_t;

   localparam logic [31:0] ADV_ACCESS_ADDR = 32'h8E89BED6;
   localparam logic [7:0]  PREAMBLE_AA     = 8'hAA;
   localparam logic [7:0]  PREAMBLE_55     = 8'h55;
   localparam int          HEADER_BYTES    = 2;

   // The preamble byte is selected by bit 0 of the access address.
   function automatic logic [7:0] preamble_for(input logic [31:0] aa);
      return aa[0] ? PREAMBLE_AA : PREAMBLE_55;
   endfunction

endpackage

// File: rtl/ble_byte_packer.sv
// -----------------------------------------------------------------------------
// ble_byte_packer
//   LSB-first serial-to-byte packer. Each accepted bit enters at bit 7 and the
//   register shifts right, so after eight bits the first bit sits at bit 0.
//   byte_done/byte_out are combinational: they describe the byte completed by
//   the bit presented this cycle, letting the parent register the strobe with
//   a single cycle of latency.
//
// Ports
//   clk       in  1  clock
//   rst_n     in  1  asynchronous active-low reset
//   clear     in  1  discard partial byte, restart bit count (wins over bit_valid)
//   bit_valid in  1  bit_in is accepted this cycle
//   bit_in    in  1  serial bit
//   byte_out  out 8  byte completed by the current bit (valid with byte_done)
//   byte_done out 1  current accepted bit is the 8th of a byte
// -----------------------------------------------------------------------------
module ble_byte_packer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       bit_valid,
   input  logic       bit_in,
   output logic [7:0] byte_out,
   output logic       byte_done
);

   logic [7:0] shreg;
   logic [2:0] bit_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= 8'h00;
         bit_cnt <= 3'd0;
      end else if (clear) begin
         shreg   <= 8'h00;
         bit_cnt <= 3'd0;
      end else if (bit_valid) begin
         shreg   <= {bit_in, shreg[7:1]};
         // Wraps 7 -> 0, so the next byte starts without an explicit clear.
         bit_cnt <= bit_cnt + 3'd1;
      end
   end

   assign byte_out  = {bit_in, shreg[7:1]};
   assign byte_done = bit_valid && !clear && (bit_cnt == 3'd7);

endmodule

// File: rtl/ble_bit_framer.sv
// -----------------------------------------------------------------------------
// ble_bit_framer
//   First stage of the BLE analyzer. Hunts the demodulated bitstream for
//   preamble + access address, then packs the PDU header and payload bits
//   LSB-first into bytes and emits them as a framed byte stream tagged with
//   the channel/RSSI seen on the last access-address bit.
//
// Stream semantics (both sides): valid-only, no backpressure. A bit is
//   transferred on every rising clock edge with valid_i=1; cycles with
//   valid_i=0 change nothing. On the output, data_valid_o is a one-cycle
//   strobe and the consumer must take every strobe; sop_o/eop_o are only
//   meaningful together with data_valid_o. abort_o tells the consumer to
//   drop whatever it already received for the current packet.
//
// Ports
//   clk_i         in  1  clock
//   rst_i         in  1  asynchronous active-low reset
//   serial_i      in  1  demodulated bit, sampled when valid_i=1
//   valid_i       in  1  bit qualifier
//   channel_i     in  7  RF channel of current bit
//   rssi_i        in  8  RSSI of current bit
//   data_o        out 8  assembled byte (header0, length, payload...)
//   data_valid_o  out 1  one-cycle byte strobe
//   sop_o         out 1  with data_valid_o: first header byte
//   eop_o         out 1  with data_valid_o: last byte of packet
//   channel_o     out 7  channel latched at access-address match
//   rssi_o        out 8  RSSI latched at access-address match
//   abort_o       out 1  one-cycle pulse: packet dropped
//   busy_o        out 1  framer is inside a packet (state != HUNT)
//   state_o       out 2  FSM state, for observation only
// -----------------------------------------------------------------------------
module ble_bit_framer
   import ble_framer_pkg::*;
#(
   parameter logic [31:0] ACCESS_ADDR  = ADV_ACCESS_ADDR,
   parameter int          MAX_PAYLOAD  = 37,
   parameter bit          CHECK_PREAMB = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          serial_i,
   input  logic          valid_i,
   input  logic [6:0]    channel_i,
   input  logic [7:0]    rssi_i,
   output logic [7:0]    data_o,
   output logic          data_valid_o,
   output logic          sop_o,
   output logic          eop_o,
   output logic [6:0]    channel_o,
   output logic [7:0]    rssi_o,
   output logic          abort_o,
   output logic          busy_o,
   output framer_state_t state_o
);

   localparam logic [7:0] MAX_LEN      = MAX_PAYLOAD[7:0];
   localparam logic [7:0] LAST_HDR_IDX = 8'(HEADER_BYTES - 1);
   localparam logic [7:0] PREAMBLE     = preamble_for(ACCESS_ADDR);

   framer_state_t state, state_nx;

   logic [39:0] window, window_nx;
   logic [39:0] window_shift;
   logic        aa_hit;

   // Header byte index while in HEADER; bytes still to come while in PAYLOAD.
   logic [7:0]  hdr_idx, hdr_idx_nx;
   logic [7:0]  remaining, remaining_nx;

   logic [7:0]  data_nx;
   logic        data_valid_nx, sop_nx, eop_nx, abort_nx;
   logic [6:0]  channel_nx;
   logic [7:0]  rssi_nx;

   logic        in_packet;
   logic        chan_bad;
   logic        pk_clear, pk_valid;
   logic [7:0]  pk_byte;
   logic        pk_done;

   // ---------------------------------------------------------------------------
   // Correlator: the match is judged on the window that already contains the
   // bit accepted this cycle, so the FSM can leave HUNT on the very next edge.
   // ---------------------------------------------------------------------------
   assign window_shift = {serial_i, window[39:1]};
   assign aa_hit = valid_i
                && (window_shift[39:8] == ACCESS_ADDR)
                && (!CHECK_PREAMB || (window_shift[7:0] == PREAMBLE));

   assign in_packet = (state != HUNT);

   // A channel hop inside a packet means the rest of the bits belong to
   // something else; the offending bit is not packed.
   assign chan_bad  = in_packet && valid_i && (channel_i != channel_o);

   // The packer is held cleared in HUNT so every packet starts on a byte edge.
   assign pk_clear  = !in_packet || chan_bad;
   assign pk_valid  = in_packet && valid_i;

   ble_byte_packer u_packer (
      .clk       (clk_i),
      .rst_n     (rst_i),
      .clear     (pk_clear),
      .bit_valid (pk_valid),
      .bit_in    (serial_i),
      .byte_out  (pk_byte),
      .byte_done (pk_done)
   );

   // ---------------------------------------------------------------------------
   // Framer FSM: next state and next registered outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx      = state;
      window_nx     = window;
      hdr_idx_nx    = hdr_idx;
      remaining_nx  = remaining;
      data_nx       = data_o;
      data_valid_nx = 1'b0;
      sop_nx        = 1'b0;
      eop_nx        = 1'b0;
      abort_nx      = 1'b0;
      channel_nx    = channel_o;
      rssi_nx       = rssi_o;

      unique case (state)
         HUNT: begin
            if (valid_i) begin
               if (aa_hit) begin
                  state_nx     = HEADER;
                  // Cleared here and frozen for the whole packet, so HUNT is
                  // re-entered with an empty window and packet bits can never
                  // produce an overlapped match.
                  window_nx    = '0;
                  hdr_idx_nx   = 8'd0;
                  remaining_nx = 8'd0;
                  channel_nx   = channel_i;
                  rssi_nx      = rssi_i;
               end else begin
                  window_nx = window_shift;
               end
            end
         end

         HEADER: begin
            if (chan_bad) begin
               abort_nx = 1'b1;
               state_nx = HUNT;
            end else if (pk_done) begin
               if (hdr_idx != LAST_HDR_IDX) begin
                  data_valid_nx = 1'b1;
                  data_nx       = pk_byte;
                  sop_nx        = (hdr_idx == 8'd0);
                  hdr_idx_nx    = hdr_idx + 8'd1;
               end else if (pk_byte > MAX_LEN) begin
                  // Oversized length: the length byte itself is not emitted.
                  abort_nx = 1'b1;
                  state_nx = HUNT;
               end else begin
                  data_valid_nx = 1'b1;
                  data_nx       = pk_byte;
                  if (pk_byte == 8'd0) begin
                     eop_nx   = 1'b1;
                     state_nx = HUNT;
                  end else begin
                     remaining_nx = pk_byte;
                     state_nx     = PAYLOAD;
                  end
               end
            end
         end

         PAYLOAD: begin
            if (chan_bad) begin
               abort_nx = 1'b1;
               state_nx = HUNT;
            end else if (pk_done) begin
               data_valid_nx = 1'b1;
               data_nx       = pk_byte;
               remaining_nx  = remaining - 8'd1;
               if (remaining == 8'd1) begin
                  eop_nx   = 1'b1;
                  state_nx = HUNT;
               end
            end
         end

         default: begin
            state_nx = HUNT;
            window_nx = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= HUNT;
         window       <= '0;
         hdr_idx      <= 8'd0;
         remaining    <= 8'd0;
         data_o       <= 8'h00;
         data_valid_o <= 1'b0;
         sop_o        <= 1'b0;
         eop_o        <= 1'b0;
         abort_o      <= 1'b0;
         channel_o    <= 7'd0;
         rssi_o       <= 8'd0;
      end else begin
         state        <= state_nx;
         window       <= window_nx;
         hdr_idx      <= hdr_idx_nx;
         remaining    <= remaining_nx;
         data_o       <= data_nx;
         data_valid_o <= data_valid_nx;
         sop_o        <= sop_nx;
         eop_o        <= eop_nx;
         abort_o      <= abort_nx;
         channel_o    <= channel_nx;
         rssi_o       <= rssi_nx;
      end
   end

   assign busy_o  = in_packet;
   assign state_o = state;

endmodule

// File: tb/tb_ble_bit_framer.sv
// -----------------------------------------------------------------------------
// tb_ble_bit_framer
//   Two framers share one input stream: dut_a requires the preamble, dut_b
//   matches on the access address alone. The driver pushes each expected byte
//   (with sop/eop and the cycle it must appear in) when the byte's last bit is
//   accepted; per-DUT monitors pop and compare on every strobe.
// -----------------------------------------------------------------------------
module tb_ble_bit_framer;
   import ble_framer_pkg::*;

   typedef logic [7:0] byte_q_t[$];

   // expected entry: {cycle[31:0], sop, eop, data[7:0]}
   localparam int EXP_W   = 42;
   localparam int MAX_LEN = 37;
   localparam logic [31:0] AA  = 32'h8E89BED6;
   localparam logic [7:0]  PRE = AA[0] ? 8'hAA : 8'h55;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- DUTs
   logic       serial_i = 1'b0;
   logic       valid_i  = 1'b0;
   logic [6:0] channel_i = 7'd0;
   logic [7:0] rssi_i    = 8'd0;

   logic [7:0] data_a, data_b;
   logic       dv_a, dv_b, sop_a, sop_b, eop_a, eop_b;
   logic [6:0] ch_a, ch_b;
   logic [7:0] rssi_a, rssi_b;
   logic       abort_a, abort_b, busy_a, busy_b;
   framer_state_t state_a, state_b;

   ble_bit_framer #(.ACCESS_ADDR(AA), .MAX_PAYLOAD(37), .CHECK_PREAMB(1'b1)) dut_a (
      .clk_i(clk), .rst_i(rst_i), .serial_i(serial_i), .valid_i(valid_i),
      .channel_i(channel_i), .rssi_i(rssi_i),
      .data_o(data_a), .data_valid_o(dv_a), .sop_o(sop_a), .eop_o(eop_a),
      .channel_o(ch_a), .rssi_o(rssi_a), .abort_o(abort_a), .busy_o(busy_a),
      .state_o(state_a)
   );

   ble_bit_framer #(.ACCESS_ADDR(AA), .MAX_PAYLOAD(37), .CHECK_PREAMB(1'b0)) dut_b (
      .clk_i(clk), .rst_i(rst_i), .serial_i(serial_i), .valid_i(valid_i),
      .channel_i(channel_i), .rssi_i(rssi_i),
      .data_o(data_b), .data_valid_o(dv_b), .sop_o(sop_b), .eop_o(eop_b),
      .channel_o(ch_b), .rssi_o(rssi_b), .abort_o(abort_b), .busy_o(busy_b),
      .state_o(state_b)
   );

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- scoreboard
   logic [EXP_W-1:0] exp_q_a[$];
   logic [EXP_W-1:0] exp_q_b[$];
   int exp_abort_a = 0, exp_abort_b = 0;
   int n_abort_a = 0, n_abort_b = 0;

   always @(negedge clk) begin : mon_a
      logic [EXP_W-1:0] e;
      if (abort_a) n_abort_a++;
      if (dv_a) begin
         if (exp_q_a.size() == 0) begin
            check_eq("a_strobe_unexpected", 32'(exp_q_a.size()), 32'd1);
         end else begin
            e = exp_q_a.pop_front();
            check_eq("a_data", 32'(data_a), 32'(e[7:0]));
            check_eq("a_sop_eop", 32'({sop_a, eop_a}), 32'(e[9:8]));
            check_eq("a_strobe_cycle", 32'(cyc), e[41:10]);
         end
      end else begin
         check_eq("a_flags_idle", 32'({sop_a, eop_a}), 32'd0);
      end
   end

   always @(negedge clk) begin : mon_b
      logic [EXP_W-1:0] e;
      if (abort_b) n_abort_b++;
      if (dv_b) begin
         if (exp_q_b.size() == 0) begin
            check_eq("b_strobe_unexpected", 32'(exp_q_b.size()), 32'd1);
         end else begin
            e = exp_q_b.pop_front();
            check_eq("b_data", 32'(data_b), 32'(e[7:0]));
            check_eq("b_sop_eop", 32'({sop_b, eop_b}), 32'(e[9:8]));
            check_eq("b_strobe_cycle", 32'(cyc), e[41:10]);
         end
      end else begin
         check_eq("b_flags_idle", 32'({sop_b, eop_b}), 32'd0);
      end
   end

   // ---------------------------------------------------------------- driver
   function automatic byte_q_t build_pkt(input logic [7:0] pre, input logic [31:0] aa,
                                         input logic [7:0] hdr, input logic [7:0] len,
                                         input int n_pl);
      byte_q_t q;
      q.push_back(pre);
      q.push_back(aa[7:0]);
      q.push_back(aa[15:8]);
      q.push_back(aa[23:16]);
      q.push_back(aa[31:24]);
      q.push_back(hdr);
      q.push_back(len);
      for (int i = 0; i < n_pl; i++) q.push_back(8'(i + 1));
      return q;
   endfunction

   // Called right after the accepting edge: the strobe is due in this cycle.
   task automatic push_exp(input logic [7:0] d, input logic sop, input logic eop,
                           input bit ok_a, input bit ok_b);
      logic [EXP_W-1:0] e;
      e = {32'(cyc), sop, eop, d};
      if (ok_a) exp_q_a.push_back(e);
      if (ok_b) exp_q_b.push_back(e);
   endtask

   task automatic send_bit(input logic b, input logic [6:0] ch, input logic [7:0] r, input bit gaps);
      int n;
      if (gaps) begin
         n = $urandom_range(0, 2);
         repeat (n) begin
            valid_i   = 1'b0;
            serial_i  = 1'($urandom_range(0, 1));
            channel_i = 7'($urandom_range(0, 127));
            rssi_i    = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
         end
      end
      valid_i   = 1'b1;
      serial_i  = b;
      channel_i = ch;
      rssi_i    = r;
      @(posedge clk); #1;
      valid_i   = 1'b0;
   endtask

   // Sends bytes LSB-first and models the expected framer output. chg_at is the
   // stream bit index from which new_ch is used; stop_at truncates the stream.
   task automatic send_stream(input byte_q_t bytes, input bit gaps, input bit ok_a, input bit ok_b,
                              input logic [6:0] ch, input int chg_at, input logic [6:0] new_ch,
                              input int stop_at);
      int bitidx, j;
      logic [7:0] len;
      logic [6:0] cur_ch;
      logic [7:0] r;
      bit done;
      len  = 8'd0;
      done = 1'b0;
      for (int i = 0; i < bytes.size() && !done; i++) begin
         for (int b = 0; b < 8 && !done; b++) begin
            bitidx = i * 8 + b;
            if (stop_at >= 0 && bitidx >= stop_at) begin
               done = 1'b1;
            end else begin
               cur_ch = (chg_at >= 0 && bitidx >= chg_at) ? new_ch : ch;
               r      = 8'($urandom_range(0, 255));
               send_bit(bytes[i][b], cur_ch, r, gaps);
               if (i == 4 && b == 7 && ok_a) begin
                  check_eq("aa_busy", 32'(busy_a), 32'd1);
                  check_eq("aa_channel", 32'(ch_a), 32'(cur_ch));
                  check_eq("aa_rssi", 32'(rssi_a), 32'(r));
               end
               if (i >= 5 && (ok_a || ok_b)) begin
                  j = i - 5;
                  if (chg_at >= 0 && bitidx == chg_at) begin
                     if (ok_a) exp_abort_a++;
                     if (ok_b) exp_abort_b++;
                     done = 1'b1;
                  end else if (b == 7) begin
                     if (j == 0) begin
                        push_exp(bytes[i], 1'b1, 1'b0, ok_a, ok_b);
                     end else if (j == 1) begin
                        len = bytes[i];
                        if (int'(len) > MAX_LEN) begin
                           if (ok_a) exp_abort_a++;
                           if (ok_b) exp_abort_b++;
                           done = 1'b1;
                        end else begin
                           push_exp(len, 1'b0, (len == 8'd0), ok_a, ok_b);
                           if (len == 8'd0) done = 1'b1;
                        end
                     end else begin
                        push_exp(bytes[i], 1'b0, (j == int'(len) + 1), ok_a, ok_b);
                        if (j == int'(len) + 1) done = 1'b1;
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic settle(input string tag);
      repeat (3) @(posedge clk);
      #1;
      check_eq({tag, "_q_a_drained"}, 32'(exp_q_a.size()), 32'd0);
      check_eq({tag, "_q_b_drained"}, 32'(exp_q_b.size()), 32'd0);
      check_eq({tag, "_aborts_a"}, 32'(n_abort_a), 32'(exp_abort_a));
      check_eq({tag, "_aborts_b"}, 32'(n_abort_b), 32'(exp_abort_b));
      check_eq({tag, "_idle_busy"}, 32'({busy_a, busy_b}), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_a_outs"}, 32'({data_a, dv_a, sop_a, eop_a, abort_a, busy_a}), 32'd0);
      check_eq({tag, "_a_tags"}, 32'({ch_a, rssi_a}), 32'd0);
      check_eq({tag, "_a_state"}, 32'(state_a), 32'(HUNT));
      check_eq({tag, "_b_outs"}, 32'({data_b, dv_b, sop_b, eop_b, abort_b, busy_b}), 32'd0);
      check_eq({tag, "_b_tags"}, 32'({ch_b, rssi_b}), 32'd0);
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      rst_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_i = 1'b1;
      @(posedge clk); #1;

      // Basic packet, contiguous bits.
      send_stream(build_pkt(PRE, AA, 8'h40, 8'h06, 6), 1'b0, 1'b1, 1'b1, 7'd37, -1, 7'd0, -1);
      settle("basic");

      // Same packet with random valid_i gaps.
      for (int k = 0; k < 3; k++) begin
         send_stream(build_pkt(PRE, AA, 8'h40, 8'h06, 6), 1'b1, 1'b1, 1'b1,
                     7'($urandom_range(0, 39)), -1, 7'd0, -1);
         settle("gaps");
      end

      // Empty payload.
      send_stream(build_pkt(PRE, AA, 8'h40, 8'h00, 0), 1'b0, 1'b1, 1'b1, 7'd12, -1, 7'd0, -1);
      settle("len0");

      // Maximum legal length.
      send_stream(build_pkt(PRE, AA, 8'h42, 8'd37, 37), 1'b1, 1'b1, 1'b1, 7'd39, -1, 7'd0, -1);
      settle("len37");

      // Oversized length: header0 only, then abort with busy already low.
      send_stream(build_pkt(PRE, AA, 8'h40, 8'h30, 0), 1'b0, 1'b1, 1'b1, 7'd37, -1, 7'd0, -1);
      @(negedge clk);
      check_eq("len48_abort_pulse", 32'(abort_a), 32'd1);
      check_eq("len48_busy_low", 32'(busy_a), 32'd0);
      settle("len48");

      // Channel hop inside the payload, then a clean packet on the new channel.
      send_stream(build_pkt(PRE, AA, 8'h40, 8'h06, 6), 1'b0, 1'b1, 1'b1, 7'd37, 7 * 8 + 2 * 8 + 3, 7'd38, -1);
      settle("chan_hop");
      send_stream(build_pkt(PRE, AA, 8'h46, 8'h03, 3), 1'b1, 1'b1, 1'b1, 7'd38, -1, 7'd0, -1);
      check_eq("chan38_latched", 32'(ch_a), 32'd38);
      settle("after_hop");

      // Access address with one bit flipped: neither framer may lock.
      send_stream(build_pkt(PRE, AA ^ 32'h0000_0100, 8'h40, 8'h06, 6), 1'b0, 1'b0, 1'b0, 7'd37, -1, 7'd0, -1);
      settle("bad_aa");

      // Wrong preamble: only the AA-only framer locks.
      send_stream(build_pkt(8'h00, AA, 8'h40, 8'h04, 4), 1'b0, 1'b0, 1'b1, 7'd37, -1, 7'd0, -1);
      settle("bad_pre");

      // Reset mid-payload: outputs drop at once, next packet is normal.
      send_stream(build_pkt(PRE, AA, 8'h40, 8'h06, 6), 1'b0, 1'b1, 1'b1, 7'd21, -1, 7'd0, 7 * 8 + 3 * 8 + 4);
      @(negedge clk);
      #1;
      check_eq("pre_reset_busy", 32'(busy_a), 32'd1);
      rst_i = 1'b0;
      #1;
      check_all_zero("mid_reset");
      check_eq("mid_reset_q_a", 32'(exp_q_a.size()), 32'd0);
      @(posedge clk); #1;
      rst_i = 1'b1;
      send_stream(build_pkt(PRE, AA, 8'h40, 8'h05, 5), 1'b1, 1'b1, 1'b1, 7'd17, -1, 7'd0, -1);
      settle("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
